// File: rtl/i2c_codec_writer.sv
// i2c_codec_writer: single-shot I2C write master for an audio codec control word.
// Sends {DEV_ADDR,W}, {reg_addr,reg_data[8]}, reg_data[7:0] as three bytes and
// checks the slave ACK after each byte. SDA and SCL are open-drain: *_en=1 pulls low.
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave stretch SCL high phases.
module i2c_codec_writer #(
    parameter int          CLK_DIV  = 4,
    parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] reg_addr,
    input  logic [8:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       sda_out,
    output logic       sda_en,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       scl_en,
    input  logic       scl_in
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   shreg;
    logic          nack;
    logic          hold;
    logic          ph_end;
    logic          slot_end;
    logic          accept;
    logic          ack_sample;

    assign sda_out = 1'b0;
    assign scl_out = 1'b0;

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL low after we released it: freeze the phase counter.
    assign hold = (phase == 2'd2) && !scl_en && !scl_in;
`else
    assign hold = 1'b0 & scl_in;
`endif

    assign accept     = (state == S_IDLE) && start;
    assign ph_end     = (cnt == CW'(CLK_DIV - 1)) && !hold;
    assign slot_end   = ph_end && (phase == 2'd3);
    assign ack_sample = (state == S_ACK) && (phase == 2'd3) && (cnt == '0);

    // Quarter-phase timing: cnt counts clocks within a phase, phase counts 4 per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= '0;
        end else if (state == S_IDLE || state == S_DONE) begin
            cnt   <= '0;
            phase <= '0;
        end else if (!hold) begin
            if (cnt == CW'(CLK_DIV - 1)) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Shift word, bit/byte counters and ACK status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            nack     <= 1'b0;
            ack_err  <= 1'b0;
        end else if (accept) begin
            shreg    <= {DEV_ADDR, 1'b0, reg_addr, reg_data};
            bit_cnt  <= '0;
            byte_cnt <= '0;
            nack     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            if (state == S_DATA && slot_end) begin
                shreg   <= {shreg[22:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (ack_sample) begin
                nack <= sda_in;
                if (sda_in)
                    ack_err <= 1'b1;
            end
            if (state == S_ACK && slot_end)
                byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state and bus line decode.
    always_comb begin
        state_nx = state;
        sda_en   = 1'b0;
        scl_en   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_START;
            end
            S_START: begin
                busy   = 1'b1;
                sda_en = phase[1];
                scl_en = (phase == 2'd3);
                if (slot_end)
                    state_nx = S_DATA;
            end
            S_DATA: begin
                busy   = 1'b1;
                sda_en = !shreg[23];
                scl_en = !phase[1];
                if (slot_end && bit_cnt == 3'd7)
                    state_nx = S_ACK;
            end
            S_ACK: begin
                busy   = 1'b1;
                scl_en = !phase[1];
                if (slot_end)
                    state_nx = (nack || byte_cnt == 2'd2) ? S_STOP : S_DATA;
            end
            S_STOP: begin
                busy   = 1'b1;
                sda_en = (phase != 2'd3);
                scl_en = !phase[1];
                if (slot_end)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_codec_writer.sv
// tb_i2c_codec_writer: randomized write transactions against a bus-level reference.
// A bus monitor decodes START/STOP and bytes from the open-drain lines and acts as
// the codec slave (ACK/NACK, optional SCL stretch); expected bytes, latency and
// error flag come from the transaction rules alone.
module tb_i2c_codec_writer;

    localparam int CLK_DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STRETCH_ADD = 20;
`else
    localparam int STRETCH_ADD = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy, done, ack_err;
    logic       sda_out, sda_en, sda_in;
    logic       scl_out, scl_en, scl_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor / slave state (written by the monitor process only).
    logic [7:0] got[$];
    int         n_start, n_stop, bitpos, byte_idx, seen_id, stretch_cnt;
    logic [7:0] shift;
    logic       slave_drive = 1'b0;
    logic       stretch = 1'b0;
    logic       stretched;
    logic       prev_scl, prev_sda, prev_scl_en;
    logic       scl_now, sda_now;

    // Slave configuration (written by the stimulus process only).
    int         txn_id = 0;
    int         nack_cfg = 3;
    logic       stretch_cfg = 1'b0;

    assign sda_in = ~(sda_en | slave_drive);
    assign scl_in = ~(scl_en | stretch);

    i2c_codec_writer #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .sda_out  (sda_out),
        .sda_en   (sda_en),
        .sda_in   (sda_in),
        .scl_out  (scl_out),
        .scl_en   (scl_en),
        .scl_in   (scl_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and codec slave model, sampling on the falling clk edge.
    initial begin
        seen_id = 0; n_start = 0; n_stop = 0; bitpos = 0; byte_idx = 0;
        stretch_cnt = 0; stretched = 1'b0; shift = '0;
        prev_scl = 1'b1; prev_sda = 1'b1; prev_scl_en = 1'b0;
        forever begin
            @(negedge clk);
            if (txn_id != seen_id) begin
                seen_id = txn_id;
                got.delete();
                n_start = 0; n_stop = 0; bitpos = 0; byte_idx = 0;
                slave_drive = 1'b0; stretched = 1'b0;
            end
            if (stretch_cnt != 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0)
                    stretch = 1'b0;
            end
            if (stretch_cfg && !stretched && byte_idx == 0 && bitpos == 3 &&
                prev_scl_en && !scl_en) begin
                stretch     = 1'b1;
                stretch_cnt = 20;
                stretched   = 1'b1;
            end
`ifdef I2C_CLK_STRETCH_EN
            scl_now = ~scl_en & ~stretch;
`else
            scl_now = ~scl_en;
`endif
            sda_now = ~(sda_en | slave_drive);
            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                n_start++;
                bitpos = 0; byte_idx = 0;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                n_stop++;
                bitpos = 0;
            end else if (!prev_scl && scl_now) begin
                if (bitpos < 8)
                    shift = {shift[6:0], sda_now};
                bitpos++;
                if (bitpos == 9) begin
                    got.push_back(shift);
                    byte_idx++;
                end
            end else if (prev_scl && !scl_now) begin
                if (bitpos == 8)
                    slave_drive = (byte_idx != nack_cfg);
                else if (bitpos == 9) begin
                    slave_drive = 1'b0;
                    bitpos = 0;
                end
            end
            prev_scl    = scl_now;
            prev_sda    = sda_now;
            prev_scl_en = scl_en;
        end
    end

    // One write: nack = byte index the slave refuses (3 = none); glitch_at / abort_at
    // are cycle offsets from the accept edge (-1 = unused); post = idle cycles watched after.
    task automatic run_txn(input logic [6:0] a, input logic [8:0] d, input int nack,
                           input logic do_stretch, input int glitch_at, input int abort_at,
                           input int post);
        int         cycles;
        int         busy_bad;
        int         extra_done;
        int         n_exp;
        int         lat;
        logic       got_done;
        logic [7:0] eb[3];
        eb[0] = {7'h1A, 1'b0};
        eb[1] = {a, d[8]};
        eb[2] = d[7:0];
        n_exp = (nack < 3) ? nack + 1 : 3;
        lat   = (8 + 36 * n_exp) * CLK_DIV + (do_stretch ? STRETCH_ADD : 0);

        @(negedge clk);
        txn_id++;
        nack_cfg    = nack;
        stretch_cfg = do_stretch;
        reg_addr    = a;
        reg_data    = d;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cycles   = 0;
        busy_bad = 0;
        got_done = 1'b0;
        check("err_clr_on_accept", ack_err, 0);
        while (cycles < 3000) begin
            if (abort_at >= 0 && cycles == abort_at) begin
                #3 rst_n = 1'b0;
                #1 check("abort_released", {busy, done, ack_err, sda_en, scl_en}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (cycles == glitch_at) begin
                reg_addr = 7'($urandom);
                reg_data = 9'($urandom);
                start    = 1'b1;
            end else if (cycles == glitch_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (!busy)
                busy_bad++;
            @(negedge clk);
            cycles++;
        end
        check("done_seen", got_done, 1);
        check("latency", cycles, lat);
        check("busy_during", busy_bad, 0);
        check("ack_err", ack_err, (nack < 3) ? 1 : 0);
        check("byte_count", got.size(), n_exp);
        for (int i = 0; i < n_exp && i < got.size(); i++)
            check($sformatf("byte%0d", i), got[i], eb[i]);
        check("start_cond", n_start, 1);
        check("stop_cond", n_stop, 1);
        @(negedge clk);
        check("done_pulse_end", {done, busy}, 0);
        extra_done = 0;
        for (int i = 0; i < post; i++) begin
            @(negedge clk);
            if (done || busy)
                extra_done++;
        end
        check("idle_after", extra_done, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        reg_addr = '0;
        reg_data = '0;
        #12;
        check("reset_state", {busy, done, ack_err, sda_en, scl_en, sda_out, scl_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(7'h0F, 9'h000, 3, 1'b0, -1, -1, 4);
        run_txn(7'h04, 9'h112, 3, 1'b0, -1, -1, 4);
        run_txn(7'h22, 9'h0A5, 0, 1'b0, -1, -1, 4);
        run_txn(7'h11, 9'h1FF, 3, 1'b0, -1, -1, 4);
        run_txn(7'h3C, 9'h155, 3, 1'b0, 100, -1, 150);
        run_txn(7'h55, 9'h0C3, 3, 1'b0, -1, 200, 0);
        run_txn(7'h7F, 9'h100, 3, 1'b0, -1, -1, 4);
        run_txn(7'h0F, 9'h000, 3, 1'b1, -1, -1, 4);
        run_txn(7'h2A, 9'h0F0, 2, 1'b0, -1, -1, 4);

        for (int t = 0; t < 14; t++) begin
            int nk;
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
            run_txn(7'($urandom), 9'($urandom), nk, 1'($urandom_range(0, 1)), -1, -1,
                    int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
